// File: rtl/mario_motion_if.sv
// Button inputs and registered motion outputs between the game top and the motion controller.
interface mario_motion_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [2:0] sprite_sel;
  logic [1:0] state;
  logic       airborne;

  modport master (
    output btn_left, btn_right, btn_jump,
    input  pos_x, pos_y, sprite_sel, state, airborne
  );

  modport slave (
    input  btn_left, btn_right, btn_jump,
    output pos_x, pos_y, sprite_sel, state, airborne
  );
endinterface

// File: rtl/mario_motion_ctrl.sv
// Mario motion controller: ground/walk/air FSM with tick-divided walking and gravity.
// Optional mid-air second jump is enabled by defining DOUBLE_JUMP_EN.
module mario_motion_ctrl #(
  parameter int MOVE_DIV     = 500000,
  parameter int GRAV_DIV     = 1000000,
  parameter int JUMP_GUARD   = 100000,
  parameter int V_INIT       = 15,
  parameter int V_MAX        = 15,
  parameter int ANIM_STEPS   = 15,
  parameter int SCREEN_LEFT  = 143,
  parameter int SCREEN_RIGHT = 702,
  parameter int GROUND_Y     = 460,
  parameter int START_X      = 300
) (
  input logic           clk,
  input logic           rst,
  mario_motion_if.slave bus
);
  localparam int MOVE_W  = $clog2(MOVE_DIV + 1);
  localparam int GRAV_W  = $clog2(GRAV_DIV + 1);
  localparam int GUARD_W = $clog2(JUMP_GUARD + 1);
  localparam int STEP_W  = $clog2(ANIM_STEPS + 1);

  localparam logic signed [5:0] V_TAKE = 6'sd0 - 6'(V_INIT - 1);
  localparam logic signed [5:0] V_CAP  = 6'(V_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, AIR = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [9:0]         pos_x_q, pos_x_d;
  logic [9:0]         pos_y_q, pos_y_d;
  logic signed [5:0]  vel_q, vel_d;
  logic [MOVE_W-1:0]  move_cnt_q, move_cnt_d;
  logic [GRAV_W-1:0]  grav_cnt_q, grav_cnt_d;
  logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic               anim_q, anim_d;
  logic               facing_q, facing_d;   // 1 = facing left
  logic [2:0]         sprite_q, sprite_d;
  logic               air_q, air_d;

  logic               go_l, go_r, dir, stepped, dj_fire;
  logic signed [10:0] y_next;

  assign go_l   = bus.btn_left & ~bus.btn_right;
  assign go_r   = bus.btn_right & ~bus.btn_left;
  assign dir    = go_l | go_r;
  assign y_next = $signed({1'b0, pos_y_q}) + $signed({{5{vel_q[5]}}, vel_q});

`ifdef DOUBLE_JUMP_EN
  logic btn_jump_d_q;
  logic dj_used_q, dj_used_d;
  assign dj_fire = bus.btn_jump & ~btn_jump_d_q & ~dj_used_q;
`else
  assign dj_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vel_d       = vel_q;
    move_cnt_d  = move_cnt_q;
    grav_cnt_d  = grav_cnt_q;
    guard_cnt_d = guard_cnt_q;
    step_cnt_d  = step_cnt_q;
    anim_d      = anim_q;
    facing_d    = facing_q;
    stepped     = 1'b0;
`ifdef DOUBLE_JUMP_EN
    dj_used_d   = dj_used_q;
`endif

    if (dir) facing_d = go_l;

    // Horizontal motion runs in every state; the divider wraps even when clamped.
    if (dir) begin
      if (move_cnt_q == MOVE_W'(MOVE_DIV - 1)) begin
        move_cnt_d = '0;
        if (go_r && pos_x_q < 10'(SCREEN_RIGHT)) begin
          pos_x_d = pos_x_q + 10'd1;
          stepped = 1'b1;
        end else if (go_l && pos_x_q > 10'(SCREEN_LEFT)) begin
          pos_x_d = pos_x_q - 10'd1;
          stepped = 1'b1;
        end
      end else begin
        move_cnt_d = move_cnt_q + MOVE_W'(1);
      end
    end else begin
      move_cnt_d = '0;
    end

    if (stepped) begin
      if (step_cnt_q == STEP_W'(ANIM_STEPS - 1)) begin
        step_cnt_d = '0;
        anim_d     = ~anim_q;
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end

    case (state_q)
      IDLE, WALK: begin
        if (guard_cnt_q < GUARD_W'(JUMP_GUARD)) guard_cnt_d = guard_cnt_q + GUARD_W'(1);
        if (bus.btn_jump && guard_cnt_q >= GUARD_W'(JUMP_GUARD)) begin
          state_d    = AIR;
          pos_y_d    = 10'(GROUND_Y - V_INIT);
          vel_d      = V_TAKE;
          grav_cnt_d = '0;
        end else begin
          state_d = dir ? WALK : IDLE;
        end
      end
      AIR: begin
        if (dj_fire) begin
          vel_d      = V_TAKE;
          grav_cnt_d = '0;
`ifdef DOUBLE_JUMP_EN
          dj_used_d  = 1'b1;
`endif
        end else if (grav_cnt_q == GRAV_W'(GRAV_DIV - 1)) begin
          grav_cnt_d = '0;
          if (y_next >= $signed(11'(GROUND_Y))) begin
            pos_y_d     = 10'(GROUND_Y);
            vel_d       = '0;
            guard_cnt_d = '0;
            state_d     = dir ? WALK : IDLE;
`ifdef DOUBLE_JUMP_EN
            dj_used_d   = 1'b0;
`endif
          end else begin
            pos_y_d = y_next[9:0];
            vel_d   = (vel_q >= V_CAP) ? V_CAP : vel_q + 6'sd1;
          end
        end else begin
          grav_cnt_d = grav_cnt_q + GRAV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Sprite code is derived from next-state values so it lines up with pos/state.
    case (state_d)
      AIR:     sprite_d = {2'b10, facing_d};
      WALK:    sprite_d = anim_d ? {2'b10, facing_d} : {2'b01, facing_d};
      default: sprite_d = {2'b00, facing_d};
    endcase
    air_d = (state_d == AIR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_x_q     <= 10'(START_X);
      pos_y_q     <= 10'(GROUND_Y);
      vel_q       <= '0;
      move_cnt_q  <= '0;
      grav_cnt_q  <= '0;
      guard_cnt_q <= '0;
      step_cnt_q  <= '0;
      anim_q      <= 1'b0;
      facing_q    <= 1'b0;
      sprite_q    <= '0;
      air_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vel_q       <= vel_d;
      move_cnt_q  <= move_cnt_d;
      grav_cnt_q  <= grav_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      step_cnt_q  <= step_cnt_d;
      anim_q      <= anim_d;
      facing_q    <= facing_d;
      sprite_q    <= sprite_d;
      air_q       <= air_d;
    end
  end

`ifdef DOUBLE_JUMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_jump_d_q <= 1'b0;
      dj_used_q    <= 1'b0;
    end else begin
      btn_jump_d_q <= bus.btn_jump;
      dj_used_q    <= dj_used_d;
    end
  end
`endif

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.sprite_sel = sprite_q;
  assign bus.state      = state_q;
  assign bus.airborne   = air_q;
endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Self-checking bench for mario_motion_ctrl with shortened dividers (4/8/10).
module tb_mario_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mario_motion_if bus();

  mario_motion_ctrl #(.MOVE_DIV(4), .GRAV_DIV(8), .JUMP_GUARD(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string name;
    int    x, y, st, spr;   // -1 = don't care
  } exp_t;

  typedef struct {
    string name;
    logic  l, r, j;
    int    cyc;
    int    x, y, st, spr;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[11];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (expq.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = expq.pop_front();
    if (e.x   >= 0) check({e.name, ".pos_x"}, bus.pos_x, e.x);
    if (e.y   >= 0) check({e.name, ".pos_y"}, bus.pos_y, e.y);
    if (e.st  >= 0) check({e.name, ".state"}, bus.state, e.st);
    if (e.spr >= 0) check({e.name, ".sprite"}, bus.sprite_sel, e.spr);
    if (e.st  >= 0) check({e.name, ".airborne"}, bus.airborne, (e.st == 2) ? 1 : 0);
  endtask

  task automatic drive(input vec_t v);
    bus.btn_left  = v.l;
    bus.btn_right = v.r;
    bus.btn_jump  = v.j;
    expq.push_back('{v.name, v.x, v.y, v.st, v.spr});
    repeat (v.cyc) @(posedge clk);
    @(negedge clk);
    compare_head();
  endtask

  // Waits at negedges until the character is no longer airborne; tracks min pos_y.
  task automatic fly(input string nm, inout int min_y);
    bit landed = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.state != 2'd2) begin
        landed = 1'b1;
        break;
      end
      if (int'(bus.pos_y) < min_y) min_y = int'(bus.pos_y);
    end
    check({nm, ".landed"}, landed, 1);
    check({nm, ".land_y"}, bus.pos_y, 460);
  endtask

  task automatic wait_y_le(input string nm, input int lim);
    bit hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.state == 2'd2 && int'(bus.pos_y) <= lim) begin
        hit = 1'b1;
        break;
      end
    end
    check({nm, ".reached"}, hit, 1);
  endtask

  initial begin
    int min_y, gnd, y_dj, exp_apex;
    tbl[0]  = '{"right16",    1'b0, 1'b1, 1'b0,   16, 304, 460, 1,  2};
    tbl[1]  = '{"right_wall", 1'b0, 1'b1, 1'b0, 1592, 702, 460, 1, -1};
    tbl[2]  = '{"wall_hold",  1'b0, 1'b1, 1'b0,   40, 702, 460, 1, -1};
    tbl[3]  = '{"release",    1'b0, 1'b0, 1'b0,    1, 702, 460, 0,  0};
    tbl[4]  = '{"left2",      1'b1, 1'b0, 1'b0,    2, 702, 460, 1, -1};
    tbl[5]  = '{"both40",     1'b1, 1'b1, 1'b0,   40, 702, 460, 0,  1};
    tbl[6]  = '{"left3",      1'b1, 1'b0, 1'b0,    3, 702, 460, 1, -1};
    tbl[7]  = '{"left1",      1'b1, 1'b0, 1'b0,    1, 701, 460, 1, -1};
    tbl[8]  = '{"right1",     1'b0, 1'b1, 1'b0,    1, 701, 460, 1, -1};
    tbl[9]  = '{"release2",   1'b0, 1'b0, 1'b0,    1, 701, 460, 0,  0};
    tbl[10] = '{"takeoff",    1'b0, 1'b0, 1'b1,    1, 701, 445, 2,  4};

    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_jump = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expq.push_back('{"reset", 300, 460, 0, 0});
    compare_head();
    rst = 1'b0;

    foreach (tbl[i]) drive(tbl[i]);

    // Jump held through the whole flight: apex, exact landing, then guard delay.
    min_y = 445;
    fly("jump_a", min_y);
    check("jump_a.apex", min_y, 340);
    check("jump_a.land_state", bus.state, 0);
    gnd = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.state == 2'd2) break;
      gnd++;
    end
    check("guard.grounded_samples", gnd, 11);
    check("guard.takeoff_y", bus.pos_y, 445);
    bus.btn_jump = 1'b0;
    min_y = 445;
    fly("jump_b", min_y);

    // Reset while rising aborts the jump on the next edge.
    repeat (12) @(negedge clk);
    bus.btn_jump = 1'b1;
    @(negedge clk);
    bus.btn_jump = 1'b0;
    check("jump_c.takeoff_state", bus.state, 2);
    wait_y_le("jump_c", 385);
    rst = 1'b1;
    expq.push_back('{"mid_air_reset", 300, 460, 0, 0});
    @(negedge clk);
    compare_head();
    rst = 1'b0;

    // Second and third jump presses mid-air.
    repeat (12) @(negedge clk);
    bus.btn_jump = 1'b1;
    @(negedge clk);
    bus.btn_jump = 1'b0;
    check("jump_d.takeoff_y", bus.pos_y, 445);
    min_y = 445;
    wait_y_le("jump_d", 400);
    y_dj = int'(bus.pos_y);
    if (y_dj < min_y) min_y = y_dj;
    bus.btn_jump = 1'b1;
    @(negedge clk);
    bus.btn_jump = 1'b0;
    check("jump_d.after_2nd_state", bus.state, 2);
    if (int'(bus.pos_y) < min_y) min_y = int'(bus.pos_y);
    repeat (40) begin
      @(negedge clk);
      if (int'(bus.pos_y) < min_y) min_y = int'(bus.pos_y);
    end
    bus.btn_jump = 1'b1;
    @(negedge clk);
    bus.btn_jump = 1'b0;
    if (int'(bus.pos_y) < min_y) min_y = int'(bus.pos_y);
    fly("jump_d", min_y);
`ifdef DOUBLE_JUMP_EN
    exp_apex = y_dj - 105;
`else
    exp_apex = 340;
`endif
    check("jump_d.apex", min_y, exp_apex);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end
endmodule
